// File: rtl/core_if_pkg.sv
// Shared core definitions used by the instruction-fetch stage: word types,
// the NOP opcode, the fetch bubble encoding and the fetch FSM/FIFO types.
package core_if_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  localparam logic [5:0]  OPCODE_NOP    = 6'h00;
  localparam logic [25:0] IF_BUBBLE_TAG = 26'd2;
  // Tag 2 keeps fetch bubbles distinct from reset NOPs (0) and decode flush NOPs (1).
  localparam instr_t      IF_BUBBLE     = {OPCODE_NOP, IF_BUBBLE_TAG};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  function automatic addr_t word_align(input addr_t a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/core_if_fifo.sv
// Prefetch buffer of {pc, instr} pairs; clear wins over push/pop in the same cycle.
module core_if_fifo
  import core_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  fetch_entry_t            push_data,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // The fetch FSM only requests when there is room, so a full push is a design bug.
      assert (!push || count != FULL);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/core_if.sv
// Instruction-fetch stage: single-outstanding imem reads, prefetch FIFO and the
// {pc, instr} output register feeding decode, with halt and redirect handling.
module core_if
  import core_if_pkg::*;
#(
  parameter addr_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   id_halt,
  input  logic   redirect,
  input  addr_t  redirect_pc,
  output logic   imem_req,
  output addr_t  imem_addr,
  input  logic   imem_ack,
  input  instr_t imem_rdata,
  output addr_t  if_pc,
  output instr_t if_instr,
  output logic   if_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_next;
  addr_t         fetch_pc;
  addr_t         req_addr;
  logic          issue;
  logic          ack_take;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // ack_take: returned word is architecturally useful (not dropped by a redirect).
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && fifo_count < FULL) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          ack_take   = !redirect;
          state_next = IDLE;
        end else if (redirect) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_req   = (state != IDLE);
  assign imem_addr  = req_addr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_pop   = !redirect && !id_halt && !fifo_empty;
  // With an empty FIFO and no halt the word bypasses straight to the outputs.
  assign fifo_push  = ack_take && (id_halt || !fifo_empty);

  core_if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data ('{pc: req_addr, instr: imem_rdata}),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (redirect)      fetch_pc <= word_align(redirect_pc);
      else if (ack_take) fetch_pc <= fetch_pc + 32'd4;
      if (issue)         req_addr <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc    <= RESET_PC;
      if_instr <= IF_BUBBLE;
      if_valid <= 1'b0;
    end else if (redirect) begin
      if_instr <= IF_BUBBLE;
      if_valid <= 1'b0;
    end else if (id_halt) begin
      if_valid <= if_valid;
    end else if (!fifo_empty) begin
      if_pc    <= fifo_head.pc;
      if_instr <= fifo_head.instr;
      if_valid <= 1'b1;
    end else if (ack_take) begin
      if_pc    <= req_addr;
      if_instr <= imem_rdata;
      if_valid <= 1'b1;
    end else begin
      if_instr <= IF_BUBBLE;
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_if.sv
// Directed bench for core_if: reset, zero-wait and delayed memory, halt,
// redirects, reset mid-request and PC wrap-around.
module tb_core_if;
  import core_if_pkg::*;

  logic   clk;
  logic   rst;
  logic   id_halt;
  logic   redirect;
  addr_t  redirect_pc;
  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_ack;
  instr_t imem_rdata;
  addr_t  if_pc;
  instr_t if_instr;
  logic   if_valid;

  logic   w_halt;
  logic   w_redirect;
  addr_t  w_redirect_pc;
  logic   w_req;
  addr_t  w_addr;
  logic   w_ack;
  instr_t w_rdata;
  addr_t  w_pc;
  instr_t w_instr;
  logic   w_valid;

  int   mem_delay;
  int   wait_cnt;
  logic stray_ack;
  int   n_pass;
  int   n_total;

  localparam addr_t DATA_OFS = 32'h1000_0000;

  core_if dut (
    .clk         (clk),
    .rst         (rst),
    .id_halt     (id_halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid)
  );

  core_if #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .id_halt     (w_halt),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (w_ack),
    .imem_rdata  (w_rdata),
    .if_pc       (w_pc),
    .if_instr    (w_instr),
    .if_valid    (w_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory responder: ack in the (mem_delay+1)-th request cycle, data = addr + DATA_OFS
  always @(negedge clk) begin
    if (!rst) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      imem_ack = 1'b0;
      if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req) begin
        if (wait_cnt == mem_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr + DATA_OFS;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    w_ack = 1'b0;
    if (rst && w_req) begin
      w_ack   = 1'b1;
      w_rdata = w_addr + DATA_OFS;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    id_halt     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    stray_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, IF_BUBBLE})
      $display("FAIL reset_main: got %h want %h", {imem_req, imem_addr, if_valid, if_pc, if_instr},
               {1'b0, 32'h0, 1'b0, 32'h0, IF_BUBBLE});
    else n_pass++;
    n_total++;
    if ({w_req, w_addr, w_valid, w_pc, w_instr} !== {1'b0, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, IF_BUBBLE})
      $display("FAIL reset_wrap: got %h want %h", {w_req, w_addr, w_valid, w_pc, w_instr},
               {1'b0, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, IF_BUBBLE});
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    addr_t pc;
    mem_delay = 0;
    do_reset();
    tick();
    n_total++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL zw_first_req: got %h want %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h0, 1'b0});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      pc = 32'(k / 2) * 32'd4;
      n_total++;
      if (k % 2 == 0) begin
        if ({if_valid, if_pc, if_instr} !== {1'b1, pc, pc + DATA_OFS})
          $display("FAIL zw_instr[%0d]: got %h want %h", k, {if_valid, if_pc, if_instr}, {1'b1, pc, pc + DATA_OFS});
        else n_pass++;
      end else begin
        if ({if_valid, if_pc, if_instr} !== {1'b0, pc, IF_BUBBLE})
          $display("FAIL zw_bubble[%0d]: got %h want %h", k, {if_valid, if_pc, if_instr}, {1'b0, pc, IF_BUBBLE});
        else n_pass++;
      end
    end
  endtask

  task automatic test_wait_delay();
    addr_t pc;
    mem_delay = 2;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      pc = 32'(k) * 32'd4;
      for (int j = 0; j < 3; j++) begin
        tick();
        n_total++;
        if ({imem_req, imem_addr, if_valid, if_instr} !== {1'b1, pc, 1'b0, IF_BUBBLE})
          $display("FAIL delay_wait[%0d.%0d]: got %h want %h", k, j,
                   {imem_req, imem_addr, if_valid, if_instr}, {1'b1, pc, 1'b0, IF_BUBBLE});
        else n_pass++;
      end
      tick();
      n_total++;
      if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, pc, pc + DATA_OFS})
        $display("FAIL delay_instr[%0d]: got %h want %h", k,
                 {imem_req, if_valid, if_pc, if_instr}, {1'b0, 1'b1, pc, pc + DATA_OFS});
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    logic exp_req [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    addr_t exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    mem_delay = 0;
    do_reset();
    tick();
    tick();
    id_halt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++;
      if ({imem_req, if_valid, if_pc, if_instr} !== {exp_req[c], 1'b1, 32'h0, DATA_OFS})
        $display("FAIL halt_hold[%0d]: got %h want %h", c,
                 {imem_req, if_valid, if_pc, if_instr}, {exp_req[c], 1'b1, 32'h0, DATA_OFS});
      else n_pass++;
    end
    id_halt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc[c], exp_pc[c] + DATA_OFS})
        $display("FAIL halt_drain[%0d]: got %h want %h", c,
                 {if_valid, if_pc, if_instr}, {1'b1, exp_pc[c], exp_pc[c] + DATA_OFS});
      else n_pass++;
      if (c == 0) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL halt_full_noreq: got %b want 0", imem_req);
        else n_pass++;
      end
    end
  endtask

  task automatic test_redirect_wait();
    mem_delay = 2;
    do_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    n_total++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 1'b0, 32'h0, IF_BUBBLE})
      $display("FAIL rdw_discard: got %h want %h", {imem_req, imem_addr, if_valid, if_pc, if_instr},
               {1'b1, 32'h0, 1'b0, 32'h0, IF_BUBBLE});
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({imem_req, if_valid, if_instr} !== {1'b0, 1'b0, IF_BUBBLE})
      $display("FAIL rdw_dropped: got %h want %h", {imem_req, if_valid, if_instr}, {1'b0, 1'b0, IF_BUBBLE});
    else n_pass++;
    tick();
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100})
      $display("FAIL rdw_new_addr: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0000_0100});
    else n_pass++;
    repeat (2) tick();
    n_total++;
    if (if_valid !== 1'b0) $display("FAIL rdw_pending: got %b want 0", if_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'h100 + DATA_OFS})
      $display("FAIL rdw_first_valid: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h100, 32'h100 + DATA_OFS});
    else n_pass++;
  endtask

  task automatic test_redirect_halt();
    mem_delay = 0;
    do_reset();
    tick();
    tick();
    id_halt = 1'b1;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    id_halt  = 1'b0;
    n_total++;
    if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b0, 32'h0, IF_BUBBLE})
      $display("FAIL rdh_bubble: got %h want %h", {imem_req, if_valid, if_pc, if_instr}, {1'b0, 1'b0, 32'h0, IF_BUBBLE});
    else n_pass++;
    tick();
    n_total++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h200, 1'b0})
      $display("FAIL rdh_cleared: got %h want %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h200, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, 32'h200 + DATA_OFS})
      $display("FAIL rdh_resume: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h200, 32'h200 + DATA_OFS});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mem_delay = 0;
    do_reset();
    repeat (3) tick();
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h4})
      $display("FAIL rmid_pre: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h4});
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, IF_BUBBLE})
      $display("FAIL rmid_async: got %h want %h", {imem_req, imem_addr, if_valid, if_pc, if_instr},
               {1'b0, 32'h0, 1'b0, 32'h0, IF_BUBBLE});
    else n_pass++;
    tick();
    rst       = 1'b1;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    n_total++;
    if ({imem_req, imem_addr, if_valid, if_instr} !== {1'b1, 32'h0, 1'b0, IF_BUBBLE})
      $display("FAIL rmid_stray_ignored: got %h want %h", {imem_req, imem_addr, if_valid, if_instr},
               {1'b1, 32'h0, 1'b0, IF_BUBBLE});
    else n_pass++;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, DATA_OFS})
      $display("FAIL rmid_restart: got %h want %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h0, DATA_OFS});
    else n_pass++;
  endtask

  task automatic test_wrap();
    addr_t exp_addr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({w_req, w_addr} !== {1'b1, exp_addr[k]})
        $display("FAIL wrap_addr[%0d]: got %h want %h", k, {w_req, w_addr}, {1'b1, exp_addr[k]});
      else n_pass++;
      tick();
      n_total++;
      if ({w_valid, w_pc, w_instr} !== {1'b1, exp_addr[k], exp_addr[k] + DATA_OFS})
        $display("FAIL wrap_instr[%0d]: got %h want %h", k, {w_valid, w_pc, w_instr},
                 {1'b1, exp_addr[k], exp_addr[k] + DATA_OFS});
      else n_pass++;
    end
  endtask

  initial begin
    rst           = 1'b0;
    id_halt       = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    stray_ack     = 1'b0;
    mem_delay     = 0;
    wait_cnt      = 0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    w_halt        = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_ack         = 1'b0;
    w_rdata       = '0;
    n_pass        = 0;
    n_total       = 0;

    test_reset();
    test_zero_wait();
    test_wait_delay();
    test_halt();
    test_redirect_wait();
    test_redirect_halt();
    test_reset_mid();
    test_wrap();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_if.md
Name: core_if

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the architectural fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents one {pc, instr} pair per cycle on if_pc/if_instr for decode to latch.
- Honours decode's id_halt (hold) and the branch/flush redirect from execute; emits NOP bubbles when no instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries, power of two, >=2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- id_halt  input  1  decode stalled; hold if_pc/if_instr.
- redirect  input  1  branch taken or pipeline flush; one-cycle pulse.
- redirect_pc  input  32 (addr_t)  new fetch address; bits [1:0] ignored, forced 0.
- imem_req  output  1  read request, held until ack.
- imem_addr  output  32 (addr_t)  word address, stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; may assert in the first cycle of imem_req.
- imem_rdata  input  32 (instr_t)  instruction word, valid with imem_ack.
- if_pc  output  32 (addr_t)  PC of presented instruction.
- if_instr  output  32 (instr_t)  presented instruction or bubble.
- if_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset values:
  - if_pc=RESET_PC, if_instr=BUBBLE, if_valid=0.
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty, FSM=IDLE.
- BUBBLE = {OPCODE_NOP, 26'd2}, distinguishable from reset NOP (26'd0) and decode's flush NOP (26'd1).
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if space available (fifo_count + outstanding < FIFO_DEPTH) and no redirect -> assert imem_req with imem_addr=fetch_pc, go WAIT.
  - WAIT: hold req/addr until imem_ack.
    - On ack: push {imem_addr, imem_rdata} (or bypass, see below), fetch_pc += 4, deassert req, go IDLE.
    - A new request is issued no earlier than the following cycle.
  - DISCARD: entered when redirect arrives while in WAIT without ack in the same cycle.
    - Keep imem_req=1 and the old address until ack; drop returned data; then go IDLE.
    - fetch_pc already equals redirect_pc.
  - Redirect coincident with ack in WAIT: data dropped, go IDLE.
- Output register, evaluated every clk edge, in priority order:
  1. redirect: if_instr=BUBBLE, if_valid=0, if_pc unchanged. FIFO cleared, fetch_pc=redirect_pc. Overrides id_halt.
  2. id_halt: all outputs hold. Ack data goes to the FIFO.
  3. FIFO non-empty: pop head to outputs, if_valid=1. Same-cycle ack pushes to tail.
  4. FIFO empty and ack this cycle (not discarded): bypass rdata/addr directly to outputs, if_valid=1.
  5. Otherwise: if_instr=BUBBLE, if_valid=0, if_pc unchanged.
- Latency: with zero-wait memory (ack in the first req cycle), the instruction appears on if_instr at the same edge that samples ack. Sustained throughput is 1 instruction per 2 cycles.
- fetch_pc arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0 with no error.
- FIFO full: no request is issued. Push with count==FIFO_DEPTH cannot occur by construction; assert it in simulation.
- Reset mid-request: everything returns to reset values immediately. A late ack after reset release while in IDLE is ignored.
- imem_ack while not in WAIT/DISCARD: ignored.

Decomposition:
- Shared core defines package:
  - addr_t, instr_t.
  - OPCODE_NOP.
  - new localparam IF_BUBBLE_TAG = 26'd2.
- Natural sub-module: core_if_fifo, a synchronous FIFO of {addr_t, instr_t} with push, pop, clear, count.
- FSM and output register stay in core_if.

Test Plan:
- Reset, zero-wait memory returning addr+32'h1000_0000:
  - if_pc sequence 0, 4, 8 with if_valid pattern 1, 0, 1 (bubble between).
  - if_instr = 0x1000_0000, 0x1000_0004, ...
- Memory with 3-cycle ack delay:
  - imem_addr stable while req high.
  - 3 bubbles (if_valid=0, if_instr={OPCODE_NOP,26'd2}) precede each instruction.
- id_halt held 4 cycles:
  - outputs frozen, FIFO fills to 2, imem_req stays 0 once full.
  - After release, the two buffered PCs appear on consecutive cycles.
- redirect to 0x0000_0103 while in WAIT, ack 2 cycles later:
  - old data dropped.
  - Next imem_addr = 0x0000_0100.
  - First valid if_pc = 0x100.
- redirect asserted during id_halt:
  - next edge if_valid=0 with bubble, FIFO cleared.
  - Fetch resumes at redirect_pc.
- RESET_PC=32'hFFFF_FFF8, zero-wait: imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
